// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS debug/loader path: the loader FSM state
// encoding, the default end-of-program marker and the debugger command byte
// that the debugger decodes into the loader's start strobe.
package mips_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RECV  = 3'd1,
      WRITE = 3'd2,
      DONE  = 3'd3,
      ERR   = 3'd4
   } loader_state_t;

   localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

   // ASCII 'L': the debugger turns this received command byte into i_start
   localparam logic [7:0]  DBG_CMD_LOAD      = 8'h4C;

   // True while the loader owns the instruction-memory write port
   function automatic logic loader_is_busy(input loader_state_t s);
      return (s == RECV) || (s == WRITE);
   endfunction

endpackage

// File: rtl/instr_loader_timeout.sv
// Inter-byte watchdog for the program loader. Counts enabled cycles since the
// last clear and flags expiry once TIMEOUT_CYCLES idle cycles have elapsed.
// Only instantiated when INSTR_LOADER_TIMEOUT_EN is defined.
module loader_timeout #(
   parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   localparam logic [31:0] LIMIT = 32'(TIMEOUT_CYCLES);

   logic [31:0] count;

   // Idle-cycle counter: restarts on clear, saturates at the limit
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         count <= '0;
      end else if (enable && (count != LIMIT)) begin
         count <= count + 32'd1;
      end
   end

   assign expire = enable && (count == LIMIT);

endmodule

// File: rtl/instr_loader.sv
// UART program loader. Assembles received bytes MSB-first into instruction
// words and writes them to consecutive instruction-memory addresses, stopping
// on the halt word, on running out of address space, or (optionally) on an
// inter-byte timeout.
// Optional feature macro: INSTR_LOADER_TIMEOUT_EN enables the inter-byte
// watchdog; without it RECV waits for bytes indefinitely.
module instr_loader
   import mips_pkg::*;
#(
   parameter int unsigned        SIZE            = 32,
   parameter int unsigned        ADDR_WIDTH      = 32,
   parameter int unsigned        MAX_INSTRUCTION = 64,
   parameter logic [SIZE-1:0]    HALT_WORD       = HALT_WORD_DEFAULT,
   parameter int unsigned        TIMEOUT_CYCLES  = 1_000_000
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_start,
   input  logic [7:0]            i_rx_data,
   input  logic                  i_rx_done,
   output logic                  o_inst_write_enable,
   output logic [ADDR_WIDTH-1:0] o_write_addr,
   output logic [SIZE-1:0]       o_write_data,
   output logic                  o_busy,
   output logic                  o_done,
   output logic                  o_error
);

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MAX_INSTRUCTION - 1);

   loader_state_t         state;
   loader_state_t         next_state;
   logic [SIZE-1:0]       word;
   logic [SIZE-1:0]       word_next;
   logic [1:0]            byte_count;
   logic [ADDR_WIDTH-1:0] addr;
   logic                  timeout_expire;

   logic                  write_d;
   logic                  busy_d;
   logic                  done_d;
   logic                  error_d;

   assign word_next = {word[SIZE-9:0], i_rx_data};

`ifdef INSTR_LOADER_TIMEOUT_EN
   logic timeout_clear;
   logic timeout_enable;

   assign timeout_enable = (state == RECV);
   assign timeout_clear  = i_rx_done || (state != RECV);

   loader_timeout #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk    (i_clk),
      .rst    (i_rst),
      .clear  (timeout_clear),
      .enable (timeout_enable),
      .expire (timeout_expire)
   );
`else
   assign timeout_expire = 1'b0;
`endif

   // State register
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state decision: a byte arriving in RECV always wins over expiry
   always_comb begin
      next_state = state;
      unique case (state)
         IDLE: begin
            if (i_start) begin
               next_state = RECV;
            end
         end
         RECV: begin
            if (i_rx_done) begin
               if (byte_count == 2'd3) begin
                  next_state = WRITE;
               end
            end else if (timeout_expire) begin
               next_state = ERR;
            end
         end
         WRITE: begin
            if (word == HALT_WORD) begin
               next_state = DONE;
            end else if (addr == LAST_ADDR) begin
               next_state = ERR;
            end else begin
               next_state = RECV;
            end
         end
         DONE:    next_state = IDLE;
         ERR:     next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Byte assembly and address tracking; a byte landing in WRITE becomes byte 0 of the next word
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         word       <= '0;
         byte_count <= '0;
         addr       <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (i_start) begin
                  word       <= '0;
                  byte_count <= '0;
                  addr       <= '0;
               end
            end
            RECV: begin
               if (i_rx_done) begin
                  word       <= word_next;
                  byte_count <= byte_count + 2'd1;
               end
            end
            WRITE: begin
               if (i_rx_done) begin
                  word       <= word_next;
                  byte_count <= byte_count + 2'd1;
               end
               if (next_state == RECV) begin
                  addr <= addr + ADDR_WIDTH'(1);
               end
            end
            default: begin
               word       <= word;
               byte_count <= byte_count;
               addr       <= addr;
            end
         endcase
      end
   end

   // Output decode from the upcoming state so every output leaves a flop
   always_comb begin
      write_d = (next_state == WRITE);
      busy_d  = loader_is_busy(next_state);
      done_d  = (next_state == DONE);
      error_d = (next_state == ERR);
   end

   // Output registers; address and data only move when a write is about to be strobed
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_inst_write_enable <= 1'b0;
         o_write_addr        <= '0;
         o_write_data        <= '0;
         o_busy              <= 1'b0;
         o_done              <= 1'b0;
         o_error             <= 1'b0;
      end else begin
         o_inst_write_enable <= write_d;
         o_busy              <= busy_d;
         o_done              <= done_d;
         o_error             <= error_d;
         if (write_d) begin
            o_write_addr <= addr;
            o_write_data <= word_next;
         end
      end
   end

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader. Expected writes are queued as bytes
// are driven and popped by a monitor whenever the write strobe fires.
module tb_instr_loader;

   localparam int unsigned MAX_INSTR = 4;
   localparam int unsigned TIMEOUT   = 100;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_start;
   logic [7:0]  i_rx_data;
   logic        i_rx_done;
   logic        o_inst_write_enable;
   logic [31:0] o_write_addr;
   logic [31:0] o_write_data;
   logic        o_busy;
   logic        o_done;
   logic        o_error;

   wr_t         exp_q[$];
   logic [7:0]  tx_q[$];
   int          tests_run   = 0;
   int          tests_failed = 0;
   int          write_count = 0;
   int          done_count  = 0;
   int          error_count = 0;

   instr_loader #(
      .SIZE            (32),
      .ADDR_WIDTH      (32),
      .MAX_INSTRUCTION (MAX_INSTR),
      .HALT_WORD       (32'hFFFF_FFFF),
      .TIMEOUT_CYCLES  (TIMEOUT)
   ) dut (
      .i_clk               (clk),
      .i_rst               (rst),
      .i_start             (i_start),
      .i_rx_data           (i_rx_data),
      .i_rx_done           (i_rx_done),
      .o_inst_write_enable (o_inst_write_enable),
      .o_write_addr        (o_write_addr),
      .o_write_data        (o_write_data),
      .o_busy              (o_busy),
      .o_done              (o_done),
      .o_error             (o_error)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Monitor: pop the scoreboard on every write strobe and tally pulses
   always @(posedge clk) begin
      #1;
      if (o_inst_write_enable) begin
         write_count++;
         if (exp_q.size() == 0) begin
            checkOutput("sb_depth", 64'(exp_q.size()), 64'd1);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            checkOutput("wr_addr", o_write_addr, e.addr);
            checkOutput("wr_data", o_write_data, e.data);
         end
      end
      if (o_done)  done_count++;
      if (o_error) error_count++;
   end

   task automatic expect_write(input logic [31:0] a, input logic [31:0] d);
      wr_t e;
      e.addr = a;
      e.data = d;
      exp_q.push_back(e);
   endtask

   task automatic queue_word(input logic [31:0] w);
      for (int i = 3; i >= 0; i--) tx_q.push_back(w[i*8 +: 8]);
   endtask

   // Drive every queued byte on consecutive cycles, then drop rx_done
   task automatic applyStimulus();
      while (tx_q.size() > 0) begin
         @(negedge clk);
         i_rx_data = tx_q.pop_front();
         i_rx_done = 1'b1;
      end
      @(negedge clk);
      i_rx_done = 1'b0;
   endtask

   task automatic start_load();
      @(negedge clk);
      i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
   endtask

   initial begin
      int d0;
      int e0;
      int w0;
      bit seen;

      rst       = 1'b1;
      i_start   = 1'b0;
      i_rx_data = 8'h00;
      i_rx_done = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("rst_we",    o_inst_write_enable, 0);
      checkOutput("rst_addr",  o_write_addr, 0);
      checkOutput("rst_data",  o_write_data, 0);
      checkOutput("rst_busy",  o_busy, 0);
      checkOutput("rst_done",  o_done, 0);
      checkOutput("rst_error", o_error, 0);
      rst = 1'b0;

      // Bytes while idle must be ignored
      queue_word(32'h11223344);
      applyStimulus();
      repeat (2) @(negedge clk);
      checkOutput("idle_rx_writes", 64'(write_count), 64'd0);
      checkOutput("idle_rx_busy",   o_busy, 0);

      // Normal load: one instruction then the halt word
      d0 = done_count;
      e0 = error_count;
      start_load();
      checkOutput("start_busy", o_busy, 1);
      expect_write(32'd0, 32'h20080005);
      queue_word(32'h20080005);
      applyStimulus();
      checkOutput("w0_strobe", o_inst_write_enable, 1);
      @(negedge clk);
      checkOutput("w0_strobe_end", o_inst_write_enable, 0);
      checkOutput("w0_busy", o_busy, 1);
      expect_write(32'd1, 32'hFFFFFFFF);
      queue_word(32'hFFFFFFFF);
      applyStimulus();
      checkOutput("halt_strobe", o_inst_write_enable, 1);
      @(negedge clk);
      checkOutput("halt_done",  o_done, 1);
      checkOutput("halt_err",   o_error, 0);
      checkOutput("halt_busy",  o_busy, 0);
      @(negedge clk);
      checkOutput("done_pulse_end", o_done, 0);
      checkOutput("hold_addr", o_write_addr, 32'd1);
      checkOutput("hold_data", o_write_data, 32'hFFFFFFFF);
      checkOutput("norm_done_cnt", 64'(done_count - d0), 64'd1);
      checkOutput("norm_err_cnt",  64'(error_count - e0), 64'd0);

      // Overflow: four non-halt words fill the memory; a start mid-load is ignored
      d0 = done_count;
      e0 = error_count;
      start_load();
      for (int i = 0; i < 4; i++) expect_write(32'(i), 32'h10000000 + 32'(i));
      queue_word(32'h10000000);
      applyStimulus();
      queue_word(32'h10000001);
      applyStimulus();
      tx_q.push_back(8'h10);
      applyStimulus();
      start_load();
      checkOutput("busy_start_ignored", o_busy, 1);
      tx_q.push_back(8'h00);
      tx_q.push_back(8'h00);
      tx_q.push_back(8'h02);
      applyStimulus();
      queue_word(32'h10000003);
      applyStimulus();
      checkOutput("ovf_strobe", o_inst_write_enable, 1);
      @(negedge clk);
      checkOutput("ovf_error", o_error, 1);
      checkOutput("ovf_done",  o_done, 0);
      checkOutput("ovf_busy",  o_busy, 0);
      @(negedge clk);
      checkOutput("ovf_done_cnt", 64'(done_count - d0), 64'd0);
      checkOutput("ovf_err_cnt",  64'(error_count - e0), 64'd1);

      // Back-to-back: next word's first byte lands in the WRITE cycle
      d0 = done_count;
      start_load();
      expect_write(32'd0, 32'hCAFEBABE);
      expect_write(32'd1, 32'hAB123456);
      expect_write(32'd2, 32'hFFFFFFFF);
      queue_word(32'hCAFEBABE);
      queue_word(32'hAB123456);
      queue_word(32'hFFFFFFFF);
      applyStimulus();
      repeat (2) @(negedge clk);
      checkOutput("b2b_done_cnt", 64'(done_count - d0), 64'd1);

      // Reset after three bytes of a word: nothing written, outputs cleared
      w0 = write_count;
      start_load();
      tx_q.push_back(8'hDE);
      tx_q.push_back(8'hAD);
      tx_q.push_back(8'hBE);
      applyStimulus();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checkOutput("mid_rst_busy", o_busy, 0);
      checkOutput("mid_rst_we",   o_inst_write_enable, 0);
      checkOutput("mid_rst_addr", o_write_addr, 0);
      checkOutput("mid_rst_data", o_write_data, 0);
      checkOutput("mid_rst_writes", 64'(write_count - w0), 64'd0);
      start_load();
      expect_write(32'd0, 32'h01020304);
      queue_word(32'h01020304);
      applyStimulus();
      checkOutput("post_rst_strobe", o_inst_write_enable, 1);

`ifdef INSTR_LOADER_TIMEOUT_EN
      // Two bytes, then silence until the watchdog fires
      @(negedge clk);
      w0 = write_count;
      e0 = error_count;
      tx_q.push_back(8'hA1);
      tx_q.push_back(8'hB2);
      applyStimulus();
      seen = 1'b0;
      for (int i = 0; i < 3 * TIMEOUT && !seen; i++) begin
         @(negedge clk);
         if (o_error) seen = 1'b1;
      end
      checkOutput("tmo_error_seen", seen, 1);
      checkOutput("tmo_busy", o_busy, 0);
      checkOutput("tmo_writes", 64'(write_count - w0), 64'd0);
      checkOutput("tmo_err_cnt", 64'(error_count - e0), 64'd1);
`else
      // Without the watchdog a long gap leaves the loader waiting
      @(negedge clk);
      e0 = error_count;
      seen = 1'b0;
      tx_q.push_back(8'hA1);
      tx_q.push_back(8'hB2);
      applyStimulus();
      repeat (2 * TIMEOUT) @(negedge clk);
      checkOutput("wait_busy", o_busy, 1);
      checkOutput("wait_err_cnt", 64'(error_count - e0), 64'd0);
      expect_write(32'd1, 32'hA1B2C3D4);
      tx_q.push_back(8'hC3);
      tx_q.push_back(8'hD4);
      applyStimulus();
      checkOutput("wait_strobe", o_inst_write_enable, 1);
      expect_write(32'd2, 32'hFFFFFFFF);
      queue_word(32'hFFFFFFFF);
      applyStimulus();
      @(negedge clk);
      checkOutput("wait_done", o_done, 1);
`endif

      repeat (3) @(negedge clk);
      checkOutput("sb_drained", 64'(exp_q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
